// File: rtl/mux_serializer_pkg.sv
// Shared types and constants for the mux-based parallel-to-serial converter.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } ser_state_t;

    localparam int MUX_W = 8;

endpackage

// File: rtl/mux_serializer_if.sv
// Parallel-in / serial-out handshake bundle; master drives, slave (the serializer) responds.
interface mux_serializer_if #(
    parameter int W = mux_pkg::MUX_W
) ();

    localparam int SW = $clog2(W);

    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic          abort;
    logic          ser_out;
    logic          ser_valid;
    logic          ser_ready;
    logic [SW-1:0] ss;
    logic          busy;
    logic          done;

    modport master (
        output in_data, in_valid, abort, ser_ready,
        input  in_ready, ser_out, ser_valid, ss, busy, done
    );

    modport slave (
        input  in_data, in_valid, abort, ser_ready,
        output in_ready, ser_out, ser_valid, ss, busy, done
    );

endinterface

// File: rtl/mux_serializer_muxn.sv
// W-to-1 bit selector: y = x[ss].
module muxn
    import mux_pkg::*;
#(
    parameter  int W  = MUX_W,
    localparam int SW = $clog2(W)
) (
    input  logic [W-1:0]  x,
    input  logic [SW-1:0] ss,
    output logic          y
);

    always_comb begin
        y = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (ss == SW'(i)) begin
                y = x[i];
            end
        end
    end

endmodule

// File: rtl/mux_serializer.sv
// Captures a W-bit word and emits it LSB first, one bit per accepted ser_ready.
module mux_serializer
    import mux_pkg::*;
#(
    parameter int W = MUX_W
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_serializer_if.slave     bus
);

    localparam int SW = $clog2(W);
    localparam logic [SW-1:0] LAST = SW'(W - 1);

    ser_state_t    state;
    logic [SW-1:0] ss;
    logic [W-1:0]  x_q;
    logic          mux_y;

    muxn #(.W(W)) u_muxn (
        .x  (x_q),
        .ss (ss),
        .y  (mux_y)
    );

    // abort outranks every transition, including an accept in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ss    <= '0;
            x_q   <= '0;
        end else if (bus.abort) begin
            state <= IDLE;
            ss    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_q   <= bus.in_data;
                        ss    <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.ser_ready) begin
                        if (ss == LAST) begin
                            ss    <= '0;
                            state <= DONE;
                        end else begin
                            ss <= ss + SW'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the registered state only, so they settle right after the edge.
    assign bus.in_ready  = (state == IDLE);
    assign bus.ser_valid = (state == SHIFT);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.ss        = ss;
    assign bus.ser_out   = (state == SHIFT) & mux_y;

endmodule

// File: doc/mux_serializer.md
MUX_SERIALIZER -- requirements
Module: mux_serializer

Interface
REQ-001 SHALL have parameter W, default 8: parallel word width, power of two, at least 2.
REQ-002 SHALL have localparam SW = $clog2(W): select width, 3 for the default.
REQ-003 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_data, input, W bits: parallel word to serialize.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a word.
REQ-008 SHALL have port abort, input, 1 bit: synchronous cancel of the current word.
REQ-009 SHALL have port ser_out, output, 1 bit: current serial bit.
REQ-010 SHALL have port ser_valid, output, 1 bit: ser_out is valid.
REQ-011 SHALL have port ser_ready, input, 1 bit: downstream accepts ser_out.
REQ-012 SHALL have port ss, output, SW bits: current mux select, i.e. bit index.
REQ-013 SHALL have port busy, output, 1 bit: high in SHIFT or DONE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse after the last bit is accepted.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered or decoded from registered state only.
REQ-016 In IDLE: in_ready=1, ser_valid=0, busy=0.
REQ-017 In IDLE, when in_valid=1: capture in_data into word register x_q, set ss=0, go to SHIFT next cycle.
REQ-018 In SHIFT or DONE: in_ready=0; in_valid and in_data are ignored.
REQ-019 In SHIFT: ser_valid=1 and ser_out = x_q[ss], selected through the internal W-to-1 mux.
REQ-020 ser_out and ss SHALL stay stable while ser_valid=1 and ser_ready=0 (backpressure holds indefinitely).
REQ-021 In SHIFT, when ser_ready=1 and ss<W-1: ss increments by 1.
REQ-022 In SHIFT, when ser_ready=1 and ss=W-1: go to DONE; ss wraps to 0.
REQ-023 Bit order SHALL be index 0 first, index W-1 last.
REQ-024 DONE SHALL last exactly one cycle: done=1, ser_valid=0; then IDLE.
REQ-025 A word SHALL NOT be accepted in the DONE cycle; minimum spacing between accepts is W+2 cycles.
REQ-026 Latency: word accepted at edge k gives the first bit valid after edge k; with ser_ready held high, done=1 in cycle k+W+1.
REQ-027 abort=1 in any state SHALL force IDLE at the next edge: ss=0, no done pulse, x_q unchanged.
REQ-028 abort SHALL take priority over a simultaneous accept, bit transfer, or DONE exit.
REQ-029 abort in IDLE together with in_valid=1 SHALL NOT accept the word.
REQ-030 ss SHALL never exceed W-1.

Reset
REQ-031 On rst_n=0, asynchronously: state=IDLE, ss=0, x_q=0, done=0, ser_valid=0, busy=0, in_ready=1, ser_out=0.
REQ-032 Reset asserted mid-word SHALL discard the word with no done pulse; after release the block behaves as after power-up.

Structure
REQ-033 Package mux_pkg SHALL hold the state enum ser_state_t (IDLE, SHIFT, DONE) and the default width constant MUX_W=8.
REQ-034 The W-to-1 select logic SHALL be a separate combinational sub-module, muxn, with inputs x[W] and ss[SW] and output y; the FSM, counter and word register stay in mux_serializer.
REQ-035 The block SHALL have no latches and a single always_ff for all sequential state.

Verification
REQ-036 Reset, then in_data=8'b00110101 with in_valid=1 for one cycle and ser_ready=1: ser_out SHALL be 1,0,1,0,1,1,0,0 over 8 cycles with ss=0..7, then done=1 for one cycle, then in_ready=1.
REQ-037 Same word, ser_ready=0 for 3 cycles at ss=2: ss stays 2 and ser_out stays 1 for those cycles; the sequence then resumes and done arrives 3 cycles later than in REQ-036.
REQ-038 in_valid=1 held with new in_data=8'hFF during SHIFT: the new word is ignored and the serial sequence is unchanged.
REQ-039 abort=1 at ss=4: next cycle IDLE, ss=0, no done; a new word 8'hA5 is then serialized as 1,0,1,0,0,1,0,1.
REQ-040 rst_n=0 asynchronously at ss=5: outputs reach reset values before the next clock edge; no done pulse appears after release.
REQ-041 Two back-to-back words 8'h0F then 8'hF0 with in_valid held high: accepts SHALL be exactly W+2=10 cycles apart.
